// File: rtl/pipe_stage_skid.sv
// Two-entry skid-buffered pipeline register carrying (res, a3, rt) between stages,
// with valid/ready handshake, synchronous flush and a combinational hazard-query port.
module pipe_stage_skid #(
    parameter int RES_W  = 3,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RES_W-1:0]  in_res,
    input  logic [ADDR_W-1:0] in_a3,
    input  logic [ADDR_W-1:0] in_rt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RES_W-1:0]  out_res,
    output logic [ADDR_W-1:0] out_a3,
    output logic [ADDR_W-1:0] out_rt,
    input  logic [ADDR_W-1:0] q_rs,
    input  logic [ADDR_W-1:0] q_rt,
    output logic              hit_rs,
    output logic              hit_rt,
    output logic [RES_W-1:0]  hit_rs_res,
    output logic [RES_W-1:0]  hit_rt_res,
    output logic [1:0]        count
);

    typedef struct packed {
        logic [RES_W-1:0]  res;
        logic [ADDR_W-1:0] a3;
        logic [ADDR_W-1:0] rt;
    } entry_t;

    // Encodings double as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t in_entry;
    logic   in_fire, out_fire;
    logic   main_vld, skid_vld;
    logic   m_rs, s_rs, m_rt, s_rt;

    assign in_entry  = '{res: in_res, a3: in_a3, rt: in_rt};
    assign in_ready  = (state_q != FULL) && reset;
    assign out_valid = (state_q != EMPTY);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign main_vld  = (state_q != EMPTY);
    assign skid_vld  = (state_q == FULL);
    assign count     = state_q;

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // Flush wins over any in_fire in the same cycle: that input is dropped.
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_entry;
                        state_d = HALF;
                    end
                end
                HALF: begin
                    if (in_fire && out_fire) begin
                        main_d = in_entry;
                    end else if (in_fire) begin
                        skid_d  = in_entry;
                        state_d = FULL;
                    end else if (out_fire) begin
                        main_d  = '0;
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        skid_d  = '0;
                        state_d = HALF;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments; payload is reset too so stale a3 never hits.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign out_res = out_valid ? main_q.res : '0;
    assign out_a3  = out_valid ? main_q.a3  : '0;
    assign out_rt  = out_valid ? main_q.rt  : '0;

    // Register 0 never hits; the younger (skid) entry wins on a double match.
    assign m_rs = main_vld && (q_rs != '0) && (main_q.a3 == q_rs);
    assign s_rs = skid_vld && (q_rs != '0) && (skid_q.a3 == q_rs);
    assign m_rt = main_vld && (q_rt != '0) && (main_q.a3 == q_rt);
    assign s_rt = skid_vld && (q_rt != '0) && (skid_q.a3 == q_rt);

    assign hit_rs     = m_rs || s_rs;
    assign hit_rt     = m_rt || s_rt;
    assign hit_rs_res = s_rs ? skid_q.res : (m_rs ? main_q.res : '0);
    assign hit_rt_res = s_rt ? skid_q.res : (m_rt ? main_q.res : '0);

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: accepted entries are queued and compared
// in order at the head; occupancy, handshake and hazard hits come from the same queue.
module tb_pipe_stage_skid;

    localparam int RES_W  = 3;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [RES_W-1:0]  in_res, out_res, hit_rs_res, hit_rt_res;
    logic [ADDR_W-1:0] in_a3, in_rt, out_a3, out_rt, q_rs, q_rt;
    logic              hit_rs, hit_rt;
    logic [1:0]        count;

    pipe_stage_skid #(.RES_W(RES_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_res(in_res), .in_a3(in_a3), .in_rt(in_rt),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_a3(out_a3), .out_rt(out_rt),
        .q_rs(q_rs), .q_rt(q_rt),
        .hit_rs(hit_rs), .hit_rt(hit_rt),
        .hit_rs_res(hit_rs_res), .hit_rt_res(hit_rt_res),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [RES_W-1:0]  res;
        logic [ADDR_W-1:0] a3;
        logic [ADDR_W-1:0] rt;
    } ent_t;

    ent_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   checks_on = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Returns {hit, res}: youngest valid entry whose a3 equals q, never for q==0.
    function automatic logic [RES_W:0] hit_model(input logic [ADDR_W-1:0] q);
        for (int i = sb.size() - 1; i >= 0; i--)
            if (q != '0 && sb[i].a3 == q) return {1'b1, sb[i].res};
        return '0;
    endfunction

    // One clock cycle: drive, check settled outputs mid-cycle, then advance the model at the edge.
    task automatic step(input logic rst, input logic fl, input logic iv,
                        input logic [RES_W-1:0] r, input logic [ADDR_W-1:0] a,
                        input logic [ADDR_W-1:0] t, input logic ordy);
        int         cnt;
        logic       exp_ready, accepted, popped;
        logic [RES_W:0] hr;
        ent_t       e;
        reset = rst; flush = fl; in_valid = iv;
        in_res = r; in_a3 = a; in_rt = t; out_ready = ordy;
        #2;
        cnt       = sb.size();
        exp_ready = rst && (cnt < 2);
        if (checks_on) begin
            check("in_ready", in_ready, exp_ready);
            check("out_valid", out_valid, cnt != 0);
            check("count", count, cnt);
            if (cnt != 0) e = sb[0];
            else e = '{res: '0, a3: '0, rt: '0};
            check("out_res", out_res, e.res);
            check("out_a3", out_a3, e.a3);
            check("out_rt", out_rt, e.rt);
            hr = hit_model(q_rs);
            check("hit_rs", hit_rs, hr[RES_W]);
            check("hit_rs_res", hit_rs_res, hr[RES_W-1:0]);
            hr = hit_model(q_rt);
            check("hit_rt", hit_rt, hr[RES_W]);
            check("hit_rt_res", hit_rt_res, hr[RES_W-1:0]);
        end
        accepted = rst && !fl && iv && exp_ready;
        popped   = (cnt != 0) && ordy;
        if (!rst || fl) begin
            sb.delete();
        end else begin
            if (popped) void'(sb.pop_front());
            if (accepted) sb.push_back('{res: r, a3: a, rt: t});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        q_rs = '0; q_rt = '0;
        // Reset held two cycles with in_valid=1; the first edge defines the state.
        step(0, 0, 1, 3'd1, 5'd8, 5'd2, 0);
        checks_on = 1'b1;
        step(0, 0, 1, 3'd1, 5'd8, 5'd2, 0);
        step(1, 0, 0, 3'd0, 5'd0, 5'd0, 0);

        // Streaming at one entry per cycle.
        q_rs = 5'd9; q_rt = 5'd10;
        step(1, 0, 1, 3'd1, 5'd8,  5'd2, 1);
        step(1, 0, 1, 3'd2, 5'd9,  5'd3, 1);
        step(1, 0, 1, 3'd3, 5'd10, 5'd4, 1);
        step(1, 0, 0, 3'd0, 5'd0,  5'd0, 1);
        step(1, 0, 0, 3'd0, 5'd0,  5'd0, 1);

        // Back-pressure: third entry is held upstream until space frees.
        step(1, 0, 1, 3'd1, 5'd8,  5'd2, 0);
        step(1, 0, 1, 3'd2, 5'd9,  5'd3, 0);
        step(1, 0, 1, 3'd3, 5'd10, 5'd4, 0);
        step(1, 0, 1, 3'd3, 5'd10, 5'd4, 1);
        step(1, 0, 1, 3'd3, 5'd10, 5'd4, 1);
        step(1, 0, 0, 3'd0, 5'd0,  5'd0, 1);
        step(1, 0, 0, 3'd0, 5'd0,  5'd0, 1);

        // Hazard: main and skid both write r8, younger res=2 must win.
        q_rs = 5'd8; q_rt = 5'd9;
        step(1, 0, 1, 3'd1, 5'd8, 5'd2, 0);
        step(1, 0, 1, 3'd2, 5'd8, 5'd3, 0);
        step(1, 0, 0, 3'd0, 5'd0, 5'd0, 0);
        check("hit_rs_full_direct", {hit_rs, hit_rs_res}, {1'b1, 3'd2});

        // Flush in FULL with in_valid=1: input dropped, block empty next cycle.
        step(1, 1, 1, 3'd5, 5'd8, 5'd7, 0);
        step(1, 0, 0, 3'd0, 5'd0, 5'd0, 0);
        check("flush_empty_a3", out_a3, 5'd0);

        // Entry with a3=0 must not hit a query of register 0.
        q_rs = 5'd0;
        step(1, 0, 1, 3'd5, 5'd0, 5'd1, 0);
        step(1, 0, 0, 3'd0, 5'd0, 5'd0, 0);
        check("zero_reg_no_hit", hit_rs, 1'b0);

        // Flush simultaneous with out_fire: head consumed, then empty.
        step(1, 1, 0, 3'd0, 5'd0, 5'd0, 1);
        step(1, 0, 0, 3'd0, 5'd0, 5'd0, 1);

        // Reset pulse in HALF, then normal acceptance.
        step(1, 0, 1, 3'd4, 5'd12, 5'd6, 0);
        step(0, 0, 0, 3'd0, 5'd0,  5'd0, 0);
        step(1, 0, 1, 3'd6, 5'd13, 5'd7, 0);
        step(1, 0, 0, 3'd0, 5'd0,  5'd0, 1);
        step(1, 0, 0, 3'd0, 5'd0,  5'd0, 1);

        // Random traffic with small register indices so hits are frequent.
        for (int i = 0; i < 400; i++) begin
            q_rs = ADDR_W'($urandom_range(0, 3));
            q_rt = ADDR_W'($urandom_range(0, 3));
            step(($urandom_range(0, 63) != 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 3) != 0), RES_W'($urandom_range(0, 7)),
                 ADDR_W'($urandom_range(0, 3)), ADDR_W'($urandom_range(0, 31)),
                 ($urandom_range(0, 1) == 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised successor to the E->M result/destination pipeline register. It carries a result-type code (res), a destination register (a3) and an rt field between two pipeline stages. It adds a valid/ready handshake, a two-entry skid buffer so back-pressure never drops an instruction, a synchronous flush that inserts a bubble, and a combinational hazard-query port the stall/forward unit reads. It sits between any two stages of the pipelined CPU; the first instance is placed between E and M.

## Interface
- RES_W, default 3, width of the result-type code.
- ADDR_W, default 5, width of register indices (a3, rt, queries).
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-low; reset==0 at posedge clears the block.
- flush  input  1  synchronous flush; discards all held entries and the current input.
- in_valid  input  1  upstream presents an entry.
- in_ready  output  1  block can accept an entry this cycle.
- in_res  input  RES_W  result-type code in.
- in_a3  input  ADDR_W  destination register in; 0 means no write.
- in_rt  input  ADDR_W  rt field in.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  downstream accepts the head entry.
- out_res  output  RES_W  head result-type code; 0 when out_valid=0.
- out_a3  output  ADDR_W  head destination; 0 when out_valid=0.
- out_rt  output  ADDR_W  head rt; 0 when out_valid=0.
- q_rs, q_rt  input  ADDR_W each  hazard query registers.
- hit_rs, hit_rt  output  1 each  a valid held entry writes the queried register.
- hit_rs_res, hit_rt_res  output  RES_W each  res of the youngest matching entry; 0 if no hit.
- count  output  2  occupancy, 0..2.

## Operation
- Storage is a main entry (head) and a skid entry (younger). Each holds res, a3 and rt.
- States:
  - EMPTY: count 0.
  - HALF: main valid, count 1.
  - FULL: main and skid valid, count 2.
- Handshake signals:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - in_ready = (state != FULL) & reset.
  - out_valid = (state != EMPTY).
- EMPTY:
  - in_fire: main <= in, go to HALF.
  - Otherwise stay.
- HALF:
  - in_fire & out_fire: main <= in, stay HALF.
  - in_fire only: skid <= in, go to FULL.
  - out_fire only: go to EMPTY.
- FULL (in_ready=0):
  - out_fire: main <= skid, go to HALF.
  - Otherwise hold.
- Priority, highest first: reset==0, then flush, then the transitions above.
  - Flush forces EMPTY and zeroes all payload registers.
  - An in_valid in the flush cycle is dropped, even though in_ready may read 1.
- A freed entry's payload is zeroed, so stale a3 values never linger.
- Hazard query:
  - Match rule: an entry matches q when it is valid, its a3 == q, and q != 0.
  - hit_x = match(main) | match(skid).
  - hit_x_res = skid.res if skid matches, else main.res if main matches, else 0. The younger entry wins.
  - Register 0 never hits.
- The query is purely combinational on current state. An entry is visible to queries from the cycle after it is accepted.
- Widths: all comparisons are exact ADDR_W-bit equality. There is no arithmetic.

## Timing
- Reset (reset==0 at posedge), next cycle:
  - state EMPTY, count=0, out_valid=0, out_res/out_a3/out_rt=0.
  - hit_* = 0, hit_*_res = 0.
  - in_ready is 0 while reset is held low and returns to 1 in the first cycle with reset==1.
- Latency: an entry accepted at edge N appears on out_* after edge N (one cycle).
- Throughput: one entry per cycle sustained while out_ready=1.
- After one back-pressure cycle, in_ready falls one cycle later (on reaching FULL). No entry is lost or duplicated.
- Simultaneous flush and out_fire: the head is still consumed downstream that cycle, and the block is EMPTY next cycle.
- Reset or flush mid-FULL drops both entries. No partial state survives.

## Test plan
- Reset: hold reset=0 for 2 cycles with in_valid=1 -> out_valid=0, count=0, in_ready=0, all outputs 0; release -> in_ready=1.
- Streaming: out_ready=1 and entries (res,a3,rt) = (1,8,2), (2,9,3), (3,10,4) on consecutive cycles -> each appears one cycle later in order, count stays 1.
- Back-pressure: out_ready=0 and push (1,8,2), (2,9,3), (3,10,4) -> count reaches 2, in_ready=0, the third entry is held upstream. Raise out_ready -> outputs appear in order 8, 9, 10 with no loss.
- Hazard query with main a3=8 res=1 and skid a3=8 res=2:
  - q_rs=8 -> hit_rs=1, hit_rs_res=2.
  - q_rs=0 with an entry a3=0 -> hit_rs=0.
  - q_rt=9 -> hit_rt=0.
- Flush: in FULL, assert flush with in_valid=1 -> next cycle count=0, out_a3=0, the input is not captured, and hit_* = 0.
- Reset mid-operation: in HALF with out_ready=0, pulse reset=0 for 1 cycle -> EMPTY, payload 0; the next accepted entry emerges normally one cycle later.
